// File: rtl/wb_write_port.sv
// Writeback owner of the regfile write port: MEM/WB register plus a late-result FIFO, merged pipeline-first.
// Optional macro WB_SCOREBOARD_EN enables busy1/busy2 hazard reporting against queued destinations.
module wb_write_port #(
  parameter int LQ_DEPTH = 4,
  parameter int LQ_AW    = 2
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             mem_we,
  input  logic [4:0]       mem_waddr,
  input  logic [31:0]      mem_wdata,
  input  logic             lr_valid,
  input  logic [4:0]       lr_waddr,
  input  logic [31:0]      lr_wdata,
  output logic             lr_ready,
  input  logic [4:0]       raddr1,
  input  logic [4:0]       raddr2,
  output logic             busy1,
  output logic             busy2,
  output logic             we,
  output logic [4:0]       waddr,
  output logic [31:0]      wdata,
  output logic [LQ_AW:0]   lq_level
);

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              vld_p0;
  logic              used_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] data_p0;

  logic [ADDR_W-1:0] lq_addr [LQ_DEPTH];
  logic [DATA_W-1:0] lq_data [LQ_DEPTH];
  logic [LQ_AW-1:0]  rd_ptr;
  logic [LQ_AW-1:0]  wr_ptr;
  logic [LQ_AW:0]    level;

  logic full;
  logic empty;
  logic sel_pipe;
  logic pop;
  logic push;

  assign full     = (level == (LQ_AW+1)'(LQ_DEPTH));
  assign empty    = (level == '0);
  assign sel_pipe = vld_p0 && !used_p0;
  assign pop      = !sel_pipe && !empty;
  // r0 pushes complete the handshake but never occupy a slot
  assign push     = lr_valid && !full && (lr_waddr != '0);

  assign lr_ready = !full;
  assign lq_level = level;

  // MEM/WB stage and queue control
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      vld_p0  <= 1'b0;
      used_p0 <= 1'b0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level   <= '0;
    end else begin
      if (flush) begin
        vld_p0  <= 1'b0;
        used_p0 <= 1'b0;
      end else if (!stall) begin
        vld_p0  <= mem_we && (mem_waddr != '0);
        used_p0 <= 1'b0;
      end else if (sel_pipe) begin
        used_p0 <= 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (!push && pop) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!stall && !flush) begin
      addr_p0 <= mem_waddr;
      data_p0 <= mem_wdata;
    end
    if (push) begin
      lq_addr[wr_ptr] <= lr_waddr;
      lq_data[wr_ptr] <= lr_wdata;
    end
  end

  // write port select
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (sel_pipe) begin
      we    = 1'b1;
      waddr = addr_p0;
      wdata = data_p0;
    end else if (!empty) begin
      we    = 1'b1;
      waddr = lq_addr[rd_ptr];
      wdata = lq_data[rd_ptr];
    end
  end

`ifdef WB_SCOREBOARD_EN
  // occupied slots are the first 'level' entries starting at the head
  always_comb begin
    busy1 = 1'b0;
    busy2 = 1'b0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if ((LQ_AW+1)'(i) < level) begin
        if (raddr1 != '0 && lq_addr[rd_ptr + LQ_AW'(i)] == raddr1) busy1 = 1'b1;
        if (raddr2 != '0 && lq_addr[rd_ptr + LQ_AW'(i)] == raddr2) busy2 = 1'b1;
      end
    end
  end
`else
  logic unused_raddr;
  assign unused_raddr = ^{raddr1, raddr2};
  assign busy1 = 1'b0;
  assign busy2 = 1'b0;
`endif

endmodule

// File: tb/tb_wb_write_port.sv
// Directed bench for wb_write_port with a write-order scoreboard.
module tb_wb_write_port;

  logic        clk;
  logic        clr_n;
  logic        stall, flush;
  logic        mem_we;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        lr_valid;
  logic [4:0]  lr_waddr;
  logic [31:0] lr_wdata;
  logic        lr_ready;
  logic [4:0]  raddr1, raddr2;
  logic        busy1, busy2;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [2:0]  lq_level;

`ifdef WB_SCOREBOARD_EN
  localparam logic SB_EN = 1'b1;
`else
  localparam logic SB_EN = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  logic [36:0] sb[$];

  wb_write_port #(.LQ_DEPTH(4), .LQ_AW(2)) dut (
    .clk(clk), .clr_n(clr_n), .stall(stall), .flush(flush),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .lr_valid(lr_valid), .lr_waddr(lr_waddr), .lr_wdata(lr_wdata), .lr_ready(lr_ready),
    .raddr1(raddr1), .raddr2(raddr2), .busy1(busy1), .busy2(busy2),
    .we(we), .waddr(waddr), .wdata(wdata), .lq_level(lq_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    sb.push_back({a, d});
  endtask

  // advance one clock, then compare this cycle's write port against the scoreboard
  task automatic tick();
    logic [36:0] e;
    @(posedge clk);
    #1;
    if (we === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", {59'd0, waddr}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", {59'd0, waddr}, {59'd0, e[36:32]});
        chk("wr_data", {32'd0, wdata}, {32'd0, e[31:0]});
      end
    end else begin
      chk("idle_port_zero", {27'd0, waddr, wdata}, 64'd0);
    end
  endtask

  initial begin
    clr_n = 1'b0; stall = 1'b0; flush = 1'b0;
    mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
    lr_valid = 1'b0; lr_waddr = '0; lr_wdata = '0;
    raddr1 = '0; raddr2 = '0;

    // reset state
    tick(); tick();
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_level", 64'(lq_level), 64'd0);
    chk("rst_ready", 64'(lr_ready), 64'd1);
    chk("rst_busy", {62'd0, busy1, busy2}, 64'd0);
    clr_n = 1'b1;
    tick();

    // single pipeline write
    mem_we = 1'b1; mem_waddr = 5'd5; mem_wdata = 32'hDEAD_BEEF;
    expect_wr(5'd5, 32'hDEAD_BEEF);
    tick();
    chk("pipe_we", 64'(we), 64'd1);
    mem_we = 1'b0;
    tick();
    chk("pipe_one_cycle", 64'(we), 64'd0);

    // two late results, pipeline idle
    lr_valid = 1'b1; lr_waddr = 5'd7; lr_wdata = 32'h11;
    expect_wr(5'd7, 32'h11);
    tick();
    lr_waddr = 5'd8; lr_wdata = 32'h22;
    expect_wr(5'd8, 32'h22);
    tick();
    lr_valid = 1'b0;
    tick();
    chk("lr_drained", 64'(sb.size()), 64'd0);

    // fill the queue while the pipeline writes every cycle
    for (int i = 0; i < 4; i++) begin
      mem_we = 1'b1; mem_waddr = 5'(10 + i); mem_wdata = 32'h100 + i;
      lr_valid = 1'b1; lr_waddr = 5'(20 + i); lr_wdata = 32'h200 + i;
      expect_wr(5'(10 + i), 32'h100 + i);
      tick();
    end
    chk("full_level", 64'(lq_level), 64'd4);
    chk("full_ready", 64'(lr_ready), 64'd0);
    mem_waddr = 5'd14; mem_wdata = 32'h104;
    lr_waddr = 5'd25; lr_wdata = 32'h999;
    expect_wr(5'd14, 32'h104);
    tick();
    chk("full_no_push", 64'(lq_level), 64'd4);
    mem_we = 1'b0; lr_valid = 1'b0;
    for (int i = 0; i < 4; i++) expect_wr(5'(20 + i), 32'h200 + i);
    tick();
    chk("ready_before_pop", 64'(lr_ready), 64'd0);
    tick();
    chk("ready_after_pop", 64'(lr_ready), 64'd1);
    chk("level_after_pop", 64'(lq_level), 64'd3);
    tick(); tick(); tick();
    chk("drain_level", 64'(lq_level), 64'd0);
    chk("drain_sb", 64'(sb.size()), 64'd0);

    // stalled pipeline entry writes once, queue drains behind it
    mem_we = 1'b1; mem_waddr = 5'd9; mem_wdata = 32'h9;
    lr_valid = 1'b1; lr_waddr = 5'd3; lr_wdata = 32'h5;
    expect_wr(5'd9, 32'h9);
    expect_wr(5'd3, 32'h5);
    tick();
    stall = 1'b1; mem_we = 1'b0; lr_valid = 1'b0;
    tick();
    chk("stall_q_we", 64'(we), 64'd1);
    tick();
    tick();
    chk("stall_once", 64'(we), 64'd0);
    chk("stall_sb", 64'(sb.size()), 64'd0);
    // flush wins over stall; flush alone also drops
    mem_we = 1'b1; mem_waddr = 5'd4; mem_wdata = 32'h4;
    flush = 1'b1;
    tick();
    chk("flush_stall_we", 64'(we), 64'd0);
    stall = 1'b0;
    tick();
    chk("flush_we", 64'(we), 64'd0);
    flush = 1'b0; mem_we = 1'b0;
    tick();

    // hazard reporting
    raddr1 = 5'd12; raddr2 = 5'd0;
    mem_we = 1'b1; mem_waddr = 5'd15; mem_wdata = 32'hF;
    lr_valid = 1'b1; lr_waddr = 5'd12; lr_wdata = 32'hC;
    expect_wr(5'd15, 32'hF);
    tick();
    chk("busy1_queued", 64'(busy1), 64'(SB_EN));
    chk("busy2_r0", 64'(busy2), 64'd0);
    mem_we = 1'b0; lr_valid = 1'b0;
    raddr2 = 5'd12;
    expect_wr(5'd12, 32'hC);
    tick();
    chk("busy1_popping", 64'(busy1), 64'(SB_EN));
    chk("busy2_popping", 64'(busy2), 64'(SB_EN));
    tick();
    chk("busy1_drained", 64'(busy1), 64'd0);
    raddr1 = '0; raddr2 = '0;

    // r0 late result: handshake only
    chk("r0_ready", 64'(lr_ready), 64'd1);
    lr_valid = 1'b1; lr_waddr = 5'd0; lr_wdata = 32'hBAD;
    tick();
    lr_valid = 1'b0;
    chk("r0_level", 64'(lq_level), 64'd0);
    tick();

    // reset mid-traffic
    mem_we = 1'b1; mem_waddr = 5'd6; mem_wdata = 32'h6;
    lr_valid = 1'b1; lr_waddr = 5'd16; lr_wdata = 32'h16;
    expect_wr(5'd6, 32'h6);
    tick();
    mem_waddr = 5'd7; mem_wdata = 32'h7; lr_waddr = 5'd17; lr_wdata = 32'h17;
    expect_wr(5'd7, 32'h7);
    tick();
    chk("pre_rst_level", 64'(lq_level), 64'd2);
    mem_we = 1'b0; lr_valid = 1'b0;
    clr_n = 1'b0;
    #1;
    chk("mid_rst_we", 64'(we), 64'd0);
    chk("mid_rst_waddr", 64'(waddr), 64'd0);
    chk("mid_rst_level", 64'(lq_level), 64'd0);
    chk("mid_rst_ready", 64'(lr_ready), 64'd1);
    tick();
    clr_n = 1'b1;
    tick(); tick();
    chk("post_rst_sb", 64'(sb.size()), 64'd0);
    chk("post_rst_level", 64'(lq_level), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
